// File: rtl/multdiv_sequencer_if.sv
// Bundle between the mul/div sequencer, the fetch path, the mul/div unit and the regfile write mux.
// Latency: none, wires only.
// Backpressure: none; the unit answers with a single md_rdy pulse and the sequencer holds stall until writeback.
interface multdiv_sequencer_if;
    logic [31:0] q_imem;
    logic        md_rdy;
    logic        md_exc;
    logic [31:0] md_result;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        busy;

    // Sequencer side
    modport slave (
        input  q_imem, md_rdy, md_exc, md_result,
        output ctrl_mult, ctrl_div, stall, wb_en, wb_reg, wb_data, busy
    );

    // Fetch / unit / regfile side
    modport master (
        output q_imem, md_rdy, md_exc, md_result,
        input  ctrl_mult, ctrl_div, stall, wb_en, wb_reg, wb_data, busy
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Multicycle sequencer for the shared mult/div unit: decode, start pulse, bounded wait, one writeback.
// Latency: decode at cycle 0, start at 1, md_rdy at cycle k, writeback at k+1 (timeout: WB at TIMEOUT+2).
// Backpressure: stall freezes the PC from decode until the writeback cycle; q_imem is ignored while busy.
module multdiv_sequencer #(
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 6,
    parameter int RSTATUS = 30,
    parameter int EXC_MUL = 4,
    parameter int EXC_DIV = 5
) (
    input  logic                clock,
    input  logic                reset,
    multdiv_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q,  state_d;
    logic             op_div_q, op_div_d;
    logic [4:0]       rd_q,     rd_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [31:0]      result_q, result_d;
    logic             exc_q,    exc_d;

    logic [4:0] opcode;
    logic [4:0] aluop;
    logic       hit_mul;
    logic       hit_div;
    logic       unused_imem_bits;

    // Instruction decode: only R-type mul/div are claimed by this block
    always_comb begin
        opcode  = bus.q_imem[31:27];
        aluop   = bus.q_imem[6:2];
        hit_mul = (opcode == 5'b00000) && (aluop == 5'b00110);
        hit_div = (opcode == 5'b00000) && (aluop == 5'b00111);
    end

    assign unused_imem_bits = ^{bus.q_imem[21:7], bus.q_imem[1:0]};

    // Next-state and latch updates for the IDLE -> START -> WAIT -> WB walk
    always_comb begin
        state_d  = state_q;
        op_div_d = op_div_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        unique case (state_q)
            IDLE: begin
                if (hit_mul || hit_div) begin
                    op_div_d = hit_div;
                    rd_d     = bus.q_imem[26:22];
                    state_d  = START;
                end
            end
            START: begin
                cnt_d   = '0;
                exc_d   = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A result arriving on the timeout cycle still counts as a result
                if (bus.md_rdy) begin
                    result_d = bus.md_result;
                    exc_d    = bus.md_exc;
                    state_d  = WB;
                end else if (cnt_q == CNT_LAST) begin
                    exc_d   = 1'b1;
                    state_d = WB;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers; reset aborts any in-flight op without a writeback
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_div_q <= 1'b0;
            rd_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_div_q <= op_div_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    // Outputs from state and latches; stall in IDLE looks at decode so the PC freezes on the decode cycle
    always_comb begin
        bus.stall     = (state_q == IDLE) ? (hit_mul || hit_div) : (state_q != WB);
        bus.ctrl_mult = (state_q == START) && !op_div_q;
        bus.ctrl_div  = (state_q == START) &&  op_div_q;
        bus.busy      = (state_q != IDLE);
        bus.wb_en     = 1'b0;
        bus.wb_reg    = '0;
        bus.wb_data   = '0;
        if (state_q == WB) begin
            if (exc_q) begin
                bus.wb_en   = 1'b1;
                bus.wb_reg  = 5'(RSTATUS);
                bus.wb_data = op_div_q ? 32'(EXC_DIV) : 32'(EXC_MUL);
            end else begin
                bus.wb_en   = (rd_q != 5'd0);
                bus.wb_reg  = rd_q;
                bus.wb_data = result_q;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench: stimulus pushes expected start pulses and writebacks, a monitor pops and compares.
module tb_multdiv_sequencer;
    localparam int TIMEOUT = 48;
    localparam int RSTATUS = 30;
    localparam int EXC_MUL = 4;
    localparam int EXC_DIV = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multdiv_sequencer_if bus_if ();

    multdiv_sequencer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (6),
        .RSTATUS (RSTATUS),
        .EXC_MUL (EXC_MUL),
        .EXC_DIV (EXC_DIV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        bit div;
        int cyc;
    } start_t;

    typedef struct {
        bit          en;
        logic [4:0]  rg;
        logic [31:0] dat;
        int          cyc;
    } wb_t;

    start_t start_q[$];
    wb_t    wb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit exp_stall = 1'b0;
    bit exp_busy  = 1'b0;
    bit done       = 1'b0;
    bit final_done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference: what the regfile must see for one mul/div instruction
    function automatic wb_t model(bit div, logic [4:0] rd, int rdy_at, bit exc,
                                  logic [31:0] res, int c0);
        wb_t w;
        bit  eff_exc;
        eff_exc = (rdy_at == 0) ? 1'b1 : exc;
        if (eff_exc) begin
            w.en  = 1'b1;
            w.rg  = 5'(RSTATUS);
            w.dat = div ? 32'(EXC_DIV) : 32'(EXC_MUL);
        end else begin
            w.en  = (rd != 5'd0);
            w.rg  = rd;
            w.dat = res;
        end
        w.cyc = c0 + ((rdy_at == 0) ? TIMEOUT : rdy_at) + 2;
        return w;
    endfunction

    function automatic logic [31:0] non_md_instr();
        logic [31:0] w;
        w = $urandom;
        if (w[31:27] == 5'd0 && (w[6:2] == 5'd6 || w[6:2] == 5'd7))
            w[6:2] = 5'd0;
        return w;
    endfunction

    function automatic logic [31:0] md_instr(bit div, logic [4:0] rd);
        logic [14:0] mid;
        logic [1:0]  lo;
        mid = 15'($urandom);
        lo  = 2'($urandom);
        return {5'd0, rd, mid, (div ? 5'd7 : 5'd6), lo};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One instruction; rdy_at = WAIT cycle (1-based) of md_rdy, 0 = never; abort_at = offset to assert reset, 0 = none
    task automatic do_op(bit md, bit div, logic [4:0] rd, int rdy_at, bit exc,
                         logic [31:0] res, int abort_at);
        int c0;
        int last;
        c0 = cyc;
        bus_if.md_rdy    = 1'($urandom);
        bus_if.md_exc    = 1'($urandom);
        bus_if.md_result = $urandom;
        if (!md) begin
            bus_if.q_imem = non_md_instr();
            exp_stall = 1'b0;
            exp_busy  = 1'b0;
            step();
            return;
        end
        bus_if.q_imem = md_instr(div, rd);
        exp_stall = 1'b1;
        exp_busy  = 1'b0;
        start_q.push_back('{div, c0 + 1});
        if (abort_at == 0)
            wb_q.push_back(model(div, rd, rdy_at, exc, res, c0));
        last = ((rdy_at == 0) ? TIMEOUT : rdy_at) + 2;
        for (int t = 1; t <= last; t++) begin
            step();
            if (abort_at != 0 && t == abort_at) begin
                reset         = 1'b1;
                bus_if.q_imem = 32'd0;
                bus_if.md_rdy = 1'b0;
                exp_stall     = 1'b0;
                exp_busy      = 1'b0;
                step();
                step();
                reset = 1'b0;
                return;
            end
            bus_if.q_imem    = ($urandom_range(0, 1) == 0) ? md_instr(1'($urandom), 5'($urandom)) : $urandom;
            bus_if.md_exc    = 1'($urandom);
            bus_if.md_result = $urandom;
            if (t == 1) begin
                bus_if.md_rdy = 1'($urandom);
            end else if (t - 1 == rdy_at) begin
                bus_if.md_rdy    = 1'b1;
                bus_if.md_exc    = exc;
                bus_if.md_result = res;
            end else begin
                bus_if.md_rdy = 1'b0;
            end
            exp_busy  = 1'b1;
            exp_stall = (t != last);
        end
        step();
    endtask

    // Monitor: every comparison lives here
    always @(negedge clock) begin
        if (reset) begin
            checks++;
            if (bus_if.busy !== 1'b0 || bus_if.wb_en !== 1'b0 ||
                bus_if.ctrl_mult !== 1'b0 || bus_if.ctrl_div !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs busy=%b wb_en=%b mult=%b div=%b required all 0 @cyc %0d",
                         bus_if.busy, bus_if.wb_en, bus_if.ctrl_mult, bus_if.ctrl_div, cyc);
            end
        end else begin
            checks++;
            if (bus_if.stall !== exp_stall) begin
                errors++;
                $display("FAIL stall actual=%b required=%b @cyc %0d", bus_if.stall, exp_stall, cyc);
            end
            checks++;
            if (bus_if.busy !== exp_busy) begin
                errors++;
                $display("FAIL busy actual=%b required=%b @cyc %0d", bus_if.busy, exp_busy, cyc);
            end
            if (bus_if.ctrl_mult === 1'b1 || bus_if.ctrl_div === 1'b1) begin
                checks++;
                if (start_q.size() == 0) begin
                    errors++;
                    $display("FAIL start_unexpected mult=%b div=%b required no pulse @cyc %0d",
                             bus_if.ctrl_mult, bus_if.ctrl_div, cyc);
                end else begin
                    start_t s;
                    s = start_q.pop_front();
                    if (bus_if.ctrl_div !== s.div || bus_if.ctrl_mult !== !s.div || cyc != s.cyc) begin
                        errors++;
                        $display("FAIL start_pulse mult=%b div=%b cyc=%0d required div=%b cyc=%0d",
                                 bus_if.ctrl_mult, bus_if.ctrl_div, cyc, s.div, s.cyc);
                    end
                end
            end
            if (bus_if.busy === 1'b1 && bus_if.stall === 1'b0) begin
                checks++;
                if (wb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected en=%b reg=%0d data=%0h required none @cyc %0d",
                             bus_if.wb_en, bus_if.wb_reg, bus_if.wb_data, cyc);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    if (bus_if.wb_en !== w.en || bus_if.wb_reg !== w.rg ||
                        bus_if.wb_data !== w.dat || cyc != w.cyc) begin
                        errors++;
                        $display("FAIL writeback en=%b reg=%0d data=%0h cyc=%0d required en=%b reg=%0d data=%0h cyc=%0d",
                                 bus_if.wb_en, bus_if.wb_reg, bus_if.wb_data, cyc,
                                 w.en, w.rg, w.dat, w.cyc);
                    end
                end
            end else begin
                checks++;
                if (bus_if.wb_en !== 1'b0) begin
                    errors++;
                    $display("FAIL wb_en_outside_wb actual=%b required=0 @cyc %0d", bus_if.wb_en, cyc);
                end
            end
        end
        if (done && !final_done) begin
            checks++;
            if (start_q.size() != 0 || wb_q.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain starts_left=%0d wbs_left=%0d required 0 0",
                         start_q.size(), wb_q.size());
            end
            final_done = 1'b1;
        end
    end

    initial begin
        bus_if.q_imem    = 32'd0;
        bus_if.md_rdy    = 1'b0;
        bus_if.md_exc    = 1'b0;
        bus_if.md_result = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        step();

        // mul r3, result 0x2A on WAIT cycle 5
        do_op(1, 0, 5'd3, 5, 1'b0, 32'h0000_002A, 0);
        // div r7 with unit exception
        do_op(1, 1, 5'd7, 3, 1'b1, 32'hDEAD_BEEF, 0);
        // mul timeout, then md_rdy on the very last WAIT cycle
        do_op(1, 0, 5'd12, 0, 1'b0, 32'h0, 0);
        do_op(1, 1, 5'd20, 0, 1'b0, 32'h0, 0);
        do_op(1, 0, 5'd12, TIMEOUT, 1'b0, 32'h1234_5678, 0);
        // rd = 0, with and without exception
        do_op(1, 0, 5'd0, 2, 1'b0, 32'hCAFE_0001, 0);
        do_op(1, 0, 5'd0, 2, 1'b1, 32'hCAFE_0002, 0);
        // reset mid-WAIT, then a fresh mul
        do_op(1, 0, 5'd9, 10, 1'b0, 32'h5555_AAAA, 4);
        do_op(1, 0, 5'd9, 3, 1'b0, 32'h0BAD_F00D, 0);
        // back-to-back mul, add, div, div, add
        do_op(1, 0, 5'd1, 1, 1'b0, 32'h0000_0011, 0);
        do_op(0, 0, 5'd0, 0, 1'b0, 32'h0, 0);
        do_op(1, 1, 5'd2, 1, 1'b0, 32'h0000_0022, 0);
        do_op(1, 1, 5'd4, 7, 1'b0, 32'h0000_0044, 0);
        do_op(0, 0, 5'd0, 0, 1'b0, 32'h0, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            int r;
            int rdy;
            r = $urandom_range(0, 7);
            if (r == 0)      rdy = 0;
            else if (r == 1) rdy = TIMEOUT;
            else             rdy = $urandom_range(1, 12);
            do_op(($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom), rdy,
                  ($urandom_range(0, 2) == 0), $urandom, 0);
        end

        bus_if.q_imem = 32'd0;
        exp_stall = 1'b0;
        exp_busy  = 1'b0;
        repeat (2) step();
        done = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
